// File: rtl/exp_align_ctrl.sv
// Exponent alignment controller: collects GROUP exponents, then emits each one's
// shift relative to the group maximum. Optional macro ALIGN_SAT_EN clamps the shift to SHIFT_MAX.
module exp_align_ctrl #(
  parameter int EXP_W     = 5,
  parameter int GROUP     = 9,
  parameter int SHIFT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_shift,
  output logic [EXP_W-1:0] out_max,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  localparam logic [3:0] LAST = 4'(GROUP - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [3:0]       idx;
  logic [EXP_W-1:0] max_q;
  logic [EXP_W-1:0] buf_q [GROUP];

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below sees the pre-edge values of cnt, idx and max_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      max_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      // NOTE: the buffer is reset on purpose so a group cut short by reset
      // leaves nothing behind; drop this loop if a plain RAM is ever needed.
      for (int i = 0; i < GROUP; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            // First element seeds the max directly; nothing stale is compared.
            buf_q[0] <= in_exp;
            max_q    <= in_exp;
            cnt      <= 4'd1;
            busy     <= 1'b1;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (in_fire) begin
            buf_q[cnt] <= in_exp;
            if (in_exp > max_q) max_q <= in_exp;
            if (cnt == LAST) begin
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        EMIT: begin
          if (out_fire) begin
            if (idx == LAST) begin
              idx       <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // max_q dominates every buffered element, so the difference never wraps.
  logic [EXP_W-1:0] diff;
  logic [EXP_W-1:0] shift_sel;

  assign diff = max_q - buf_q[idx];

`ifdef ALIGN_SAT_EN
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(SHIFT_MAX);
  assign shift_sel = (diff > SHIFT_LIM) ? SHIFT_LIM : diff;
`else
  assign shift_sel = diff;
`endif

  assign out_shift = out_valid ? shift_sel : '0;
  assign out_max   = out_valid ? max_q : '0;
  assign out_idx   = out_valid ? idx : '0;
  assign out_last  = out_valid && (idx == LAST);

endmodule

// File: tb/tb_exp_align_ctrl.sv
// Directed bench for exp_align_ctrl (default parameters): group emit, stall,
// saturation boundary, mid-group reset and bubbled input.
module tb_exp_align_ctrl;

  typedef int vec_t [9];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_exp = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_shift;
  logic [4:0] out_max;
  logic [3:0] out_idx;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  exp_align_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shift (out_shift),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic accept(input int v);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_exp   = 5'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_group(input vec_t v, input bit bubble);
    for (int i = 0; i < 9; i++) begin
      accept(v[i]);
      if (bubble && i < 8) @(negedge clk);
    end
  endtask

  // Starts at the negedge right after the last accept; stall_idx < 0 means no stall.
  task automatic drain(input string tag, input vec_t shifts, input int mx, input int stall_idx);
    check({tag, "_valid_lat"}, out_valid, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check({tag, "_stall_idx"}, out_idx, 32'(i));
          check({tag, "_stall_shift"}, out_shift, 32'(shifts[i]));
          check({tag, "_stall_valid"}, out_valid, 1);
          check({tag, "_stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
      end
      check({tag, "_shift"}, out_shift, 32'(shifts[i]));
      check({tag, "_max"}, out_max, 32'(mx));
      check({tag, "_idx"}, out_idx, 32'(i));
      check({tag, "_last"}, out_last, (i == 8) ? 1 : 0);
      check({tag, "_in_ready_emit"}, in_ready, 0);
      @(negedge clk);
    end
    check({tag, "_valid_done"}, out_valid, 0);
    check({tag, "_fields_zero"}, {out_shift, out_max, out_idx, out_last}, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  vec_t g1  = '{3, 7, 1, 7, 0, 2, 9, 4, 5};
  vec_t s1  = '{6, 2, 8, 2, 9, 7, 0, 5, 4};
  vec_t g31 = '{31, 31, 31, 31, 31, 31, 31, 31, 31};
  vec_t z   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  vec_t gs  = '{31, 0, 31, 31, 31, 31, 31, 31, 31};
`ifdef ALIGN_SAT_EN
  vec_t ss  = '{0, 15, 0, 0, 0, 0, 0, 0, 0};
`else
  vec_t ss  = '{0, 31, 0, 0, 0, 0, 0, 0, 0};
`endif
  vec_t gr  = '{1, 2, 3, 4, 5, 6, 7, 8, 8};
  vec_t sr  = '{7, 6, 5, 4, 3, 2, 1, 0, 0};

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_shift", out_shift, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // Back-to-back reference group
    accept(g1[0]);
    check("busy_collect", busy, 1);
    for (int i = 1; i < 9; i++) accept(g1[i]);
    drain("b2b", s1, 9, -1);

    // All-equal maximum exponents
    send_group(g31, 1'b0);
    drain("eq31", z, 31, -1);

    // Output stall at idx 4
    send_group(g1, 1'b0);
    drain("stall", s1, 9, 4);

    // Large difference: raw or saturated shift
    send_group(gs, 1'b0);
    drain("sat", ss, 31, -1);

    // Reset mid-collect, then a clean group
    accept(1); accept(30); accept(2); accept(3); accept(4);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    send_group(gr, 1'b0);
    drain("rst", sr, 8, -1);

    // Bubble between every accept
    send_group(g1, 1'b1);
    drain("bubble", s1, 9, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_align_ctrl.md
EXP_ALIGN_CTRL -- requirements
Module: exp_align_ctrl

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width in bits.
REQ-002 SHALL have parameter GROUP, default 9, exponents per alignment group; legal range 2..15.
REQ-003 SHALL have parameter SHIFT_MAX, default 15, shift saturation limit; used only when ALIGN_SAT_EN is defined.
REQ-004 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_exp is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts an exponent this cycle.
REQ-008 SHALL have port in_exp  input  EXP_W  unsigned element exponent.
REQ-009 SHALL have port out_valid  output  1  out_* fields are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-011 SHALL have port out_shift  output  EXP_W  alignment shift, group max minus element exponent.
REQ-012 SHALL have port out_max  output  EXP_W  group maximum exponent.
REQ-013 SHALL have port out_idx  output  4  element index within group, 0..GROUP-1.
REQ-014 SHALL have port out_last  output  1  marks element GROUP-1.
REQ-015 SHALL have port busy  output  1  high in COLLECT or EMIT.

Function
REQ-016 SHALL implement an FSM with states IDLE, COLLECT and EMIT.
REQ-017 SHALL drive in_ready high in IDLE and COLLECT, low in EMIT; an input transfer occurs on in_valid && in_ready.
REQ-018 SHALL store each accepted exponent at buffer position cnt, then increment cnt.
REQ-019 SHALL load the running max directly from the first accepted element (IDLE->COLLECT), with no compare against stale state.
REQ-020 SHALL update max on later accepts as in_exp > max ? in_exp : max; ties keep the held value.
REQ-021 SHALL, on the GROUP-th accept, enter EMIT and clear cnt; out_valid is high on the next cycle (latency 1 cycle from last accept).
REQ-022 SHALL, in EMIT, hold out_valid=1 with out_shift = max - buf[idx], out_max = max, out_idx = idx, out_last = (idx == GROUP-1).
REQ-023 SHALL advance idx only on out_valid && out_ready; all out_* fields stay stable while out_ready is low.
REQ-024 SHALL, on the transfer with out_last=1, enter IDLE and clear idx, so in_ready rises the next cycle.
REQ-025 SHALL compute out_shift as an unsigned EXP_W value; it is never negative because max >= every element.
REQ-026 SHALL ignore in_valid during EMIT; no input is buffered or dropped silently while in_ready is low.
REQ-027 SHALL tolerate idle cycles (in_valid low) between accepts in COLLECT with no effect on the result.
REQ-028 SHALL drive out_shift, out_idx, out_last and out_max to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, while rst_n is low, force state to IDLE; cnt, idx, max and buffer to 0; out_valid, busy and in_ready to 0.
REQ-030 SHALL release in_ready=1 on the first clk edge after rst_n deasserts.
REQ-031 SHALL discard a partial group on reset mid-COLLECT or mid-EMIT; no residual element or max affects the next group.

Configuration
REQ-032 SHALL, with ALIGN_SAT_EN defined, output out_shift = min(max - buf[idx], SHIFT_MAX).
REQ-033 SHALL, with ALIGN_SAT_EN undefined, output the raw difference; SHIFT_MAX is then unused.

Verification
REQ-034 SHALL cover back-to-back input 3,7,1,7,0,2,9,4,5 with out_ready=1 -> out_max=9, shifts 6,2,8,2,9,7,0,5,4, out_last on idx 8, out_valid the cycle after the 9th accept.
REQ-035 SHALL cover all nine exponents equal to 31 -> out_max=31, all shifts 0.
REQ-036 SHALL cover out_ready low for 3 cycles at idx 4 -> fields frozen, idx holds at 4, in_ready=0 throughout EMIT.
REQ-037 SHALL cover input 31,0,31,31,31,31,31,31,31 with SHIFT_MAX=15 -> idx1 shift 15 with ALIGN_SAT_EN, 31 without.
REQ-038 SHALL cover rst_n pulsed after 5 accepts including value 30, then group 1..8,8 -> out_max=8, state IDLE after reset.
REQ-039 SHALL cover the REQ-034 group with one bubble cycle between every accept -> identical outputs.
